// File: rtl/swap_pager.sv
// Page-transfer engine between a local page RAM and the swap port of the HPS bridge.
// Page-in streams swap reads into local writes; page-out streams local reads into swap writes.
module swap_pager #(
  parameter int PAGE_WORDS   = 256,
  parameter int LOCAL_AW     = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                start,
  input  logic                dir,
  input  logic                meta,
  input  logic [31:0]         swapBase,
  input  logic [LOCAL_AW-1:0] localBase,
  output logic                busy,
  output logic                done,
  output logic                swapMeta,
  output logic [31:0]         swapAddress,
  output logic                swapRden,
  input  logic [31:0]         swapQ,
  output logic                swapWren,
  output logic [31:0]         swapData,
  output logic [LOCAL_AW-1:0] localAddress,
  output logic                localRden,
  input  logic [31:0]         localQ,
  output logic                localWren,
  output logic [31:0]         localData
);

  localparam int CW = $clog2(PAGE_WORDS) + 1;
  localparam int PW = (READ_LATENCY > 1) ? READ_LATENCY : 1;
  localparam logic [CW-1:0] LAST = CW'(PAGE_WORDS);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  state_t              state_q, state_d;
  logic                dir_q, dir_d;
  logic                meta_q, meta_d;
  logic [31:0]         swapBase_q, swapBase_d;
  logic [LOCAL_AW-1:0] localBase_q, localBase_d;
  logic [CW-1:0]       issueCnt_q, issueCnt_d;
  logic [CW-1:0]       compCnt_q, compCnt_d;
  logic [PW-1:0]       pipe_q, pipe_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [31:0]         swapAddr_q, swapAddr_d;
  logic                swapRden_q, swapRden_d;
  logic                swapWren_q, swapWren_d;
  logic [LOCAL_AW-1:0] localAddr_q, localAddr_d;
  logic                localRden_q, localRden_d;
  logic                localWren_q, localWren_d;
  logic                issueNow;
  logic                writeTap;

  // Page-out reads come back after one cycle; page-in waits the full swap latency.
  assign writeTap = dir_q ? pipe_q[0] : pipe_q[PW-1];

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= IDLE;
      dir_q       <= 1'b0;
      meta_q      <= 1'b0;
      swapBase_q  <= '0;
      localBase_q <= '0;
      issueCnt_q  <= '0;
      compCnt_q   <= '0;
      pipe_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      swapAddr_q  <= '0;
      swapRden_q  <= 1'b0;
      swapWren_q  <= 1'b0;
      localAddr_q <= '0;
      localRden_q <= 1'b0;
      localWren_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      meta_q      <= meta_d;
      swapBase_q  <= swapBase_d;
      localBase_q <= localBase_d;
      issueCnt_q  <= issueCnt_d;
      compCnt_q   <= compCnt_d;
      pipe_q      <= pipe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      swapAddr_q  <= swapAddr_d;
      swapRden_q  <= swapRden_d;
      swapWren_q  <= swapWren_d;
      localAddr_q <= localAddr_d;
      localRden_q <= localRden_d;
      localWren_q <= localWren_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    meta_d      = meta_q;
    swapBase_d  = swapBase_q;
    localBase_d = localBase_q;
    issueCnt_d  = issueCnt_q;
    compCnt_d   = compCnt_q;
    pipe_d      = pipe_q << 1;
    busy_d      = busy_q;
    done_d      = 1'b0;
    swapAddr_d  = swapAddr_q;
    swapRden_d  = 1'b0;
    swapWren_d  = 1'b0;
    localAddr_d = localAddr_q;
    localRden_d = 1'b0;
    localWren_d = 1'b0;
    issueNow    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          dir_d       = dir;
          meta_d      = meta;
          swapBase_d  = swapBase;
          localBase_d = localBase;
          compCnt_d   = '0;
          issueCnt_d  = CW'(1);
          busy_d      = 1'b1;
          issueNow    = 1'b1;
          state_d     = ISSUE;
          if (dir) begin
            localRden_d = 1'b1;
            localAddr_d = localBase;
          end else begin
            swapRden_d = 1'b1;
            swapAddr_d = swapBase;
          end
        end
      end
      ISSUE: begin
        if (issueCnt_q == LAST) begin
          state_d = DRAIN;
        end else begin
          issueNow   = 1'b1;
          issueCnt_d = issueCnt_q + CW'(1);
          if (dir_q) begin
            localRden_d = 1'b1;
            localAddr_d = localBase_q + LOCAL_AW'(issueCnt_q);
          end else begin
            swapRden_d = 1'b1;
            swapAddr_d = swapBase_q + 32'(issueCnt_q);
          end
        end
      end
      DRAIN: begin
        if (compCnt_q == LAST) begin
          state_d = FINISH;
          done_d  = 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        meta_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // Writes use the port opposite to the reads, so they never collide with issue.
    if (writeTap) begin
      compCnt_d = compCnt_q + CW'(1);
      if (dir_q) begin
        swapWren_d = 1'b1;
        swapAddr_d = swapBase_q + 32'(compCnt_q);
      end else begin
        localWren_d = 1'b1;
        localAddr_d = localBase_q + LOCAL_AW'(compCnt_q);
      end
    end

    pipe_d[0] = issueNow;
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign swapMeta     = meta_q;
  assign swapAddress  = swapAddr_q;
  assign swapRden     = swapRden_q;
  assign swapWren     = swapWren_q;
  assign localAddress = localAddr_q;
  assign localRden    = localRden_q;
  assign localWren    = localWren_q;

  // Read data is valid only in its write cycle, so it is forwarded under the registered strobe.
  assign swapData  = swapWren_q  ? localQ : '0;
  assign localData = localWren_q ? swapQ  : '0;

endmodule
